instruction_fetch_decoder: RTL and testbench

- Control end of the 4-bit microprocessor datapath. Fetches 8-bit instructions from a slow, variable-latency program ROM using a req/valid handshake.
- Holds the program counter and decodes each instruction into the select and enable strobes consumed by the computational unit.
- Resolves jumps using the computational unit's registered zero flag.
- Produces exactly one execute cycle per instruction; all register enables are zero outside that cycle.

---
 rtl/cpu_isa_pkg.sv | 56 +++++
 rtl/instruction_decode.sv | 61 ++++++
 rtl/instruction_fetch_decoder.sv | 91 +++++++++
 tb/tb_instruction_fetch_decoder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// rtl/cpu_isa_pkg.sv - shared ISA definitions for the 4-bit CPU control unit
package cpu_isa_pkg;

  typedef enum logic {
    FETCH   = 1'b0,
    EXECUTE = 1'b1
  } state_t;

  // data_bus source select codes
  localparam logic [3:0] SRC_X0    = 4'd0;
  localparam logic [3:0] SRC_X1    = 4'd1;
  localparam logic [3:0] SRC_Y0    = 4'd2;
  localparam logic [3:0] SRC_Y1    = 4'd3;
  localparam logic [3:0] SRC_R     = 4'd4;
  localparam logic [3:0] SRC_M     = 4'd5;
  localparam logic [3:0] SRC_I     = 4'd6;
  localparam logic [3:0] SRC_DM    = 4'd7;
  localparam logic [3:0] SRC_PM    = 4'd8;
  localparam logic [3:0] SRC_IPINS = 4'd9;

  // reg_en bit positions
  localparam int EN_X0   = 0;
  localparam int EN_X1   = 1;
  localparam int EN_Y0   = 2;
  localparam int EN_Y1   = 3;
  localparam int EN_R    = 4;
  localparam int EN_M    = 5;
  localparam int EN_I    = 6;
  localparam int EN_DM   = 7;
  localparam int EN_OREG = 8;

  // opcode prefixes, matched against the top bits of ir
  localparam logic       OP_LOAD = 1'b0;
  localparam logic [1:0] OP_MOVE = 2'b10;
  localparam logic [2:0] OP_ALU  = 3'b110;
  localparam logic [3:0] OP_JMP  = 4'b1110;
  localparam logic [3:0] OP_JNZ  = 4'b1111;

  // Destination field of load/move to its one-hot write enable; code 4 is o_reg
  function automatic logic [8:0] dst_to_en(input logic [2:0] dst);
    logic [8:0] en;
    en = '0;
    case (dst)
      3'd0: en[EN_X0]   = 1'b1;
      3'd1: en[EN_X1]   = 1'b1;
      3'd2: en[EN_Y0]   = 1'b1;
      3'd3: en[EN_Y1]   = 1'b1;
      3'd4: en[EN_OREG] = 1'b1;
      3'd5: en[EN_M]    = 1'b1;
      3'd6: en[EN_I]    = 1'b1;
      default: en[EN_DM] = 1'b1;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/instruction_decode.sv
// rtl/instruction_decode.sv - combinational decode of ir into datapath strobes and jump control
module instruction_decode
  import cpu_isa_pkg::*;
(
  input  logic [7:0] ir,
  input  logic       r_eq_0,
  output logic [3:0] source_sel,
  output logic [8:0] reg_en,
  output logic       i_sel,
  output logic       x_sel,
  output logic       y_sel,
  output logic       jump_taken,
  output logic [7:0] jump_target
);

  logic [2:0] dst;
  logic       writes_reg;

  assign jump_target = {ir[3:0], 4'b0000};

  // Classify by opcode prefix, then add the dm auto-increment of i for load/move
  always_comb begin
    source_sel = SRC_X0;
    reg_en     = '0;
    i_sel      = 1'b0;
    x_sel      = 1'b0;
    y_sel      = 1'b0;
    jump_taken = 1'b0;
    dst        = ir[6:4];
    writes_reg = 1'b0;

    if (ir[7] == OP_LOAD) begin
      dst        = ir[6:4];
      source_sel = SRC_PM;
      writes_reg = 1'b1;
    end else if (ir[7:6] == OP_MOVE) begin
      dst        = ir[5:3];
      // a move onto itself is repurposed as a read of the input pins
      source_sel = (ir[2:0] == ir[5:3]) ? SRC_IPINS : {1'b0, ir[2:0]};
      writes_reg = 1'b1;
    end else if (ir[7:5] == OP_ALU) begin
      x_sel        = ir[4];
      y_sel        = ir[3];
      reg_en[EN_R] = 1'b1;
    end else if (ir[7:4] == OP_JMP) begin
      jump_taken = 1'b1;
    end else begin
      jump_taken = ~r_eq_0;
    end

    if (writes_reg) begin
      reg_en = dst_to_en(dst);
      // any dm access steps i to i+m, unless i itself is the destination
      if ((dst == 3'd7 || source_sel == SRC_DM) && dst != 3'd6) begin
        reg_en[EN_I] = 1'b1;
        i_sel        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/instruction_fetch_decoder.sv
// rtl/instruction_fetch_decoder.sv - fetch/execute sequencer, program counter and instruction register
module instruction_fetch_decoder
  import cpu_isa_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            sync_reset,
  input  logic [7:0]      rom_data,
  input  logic            rom_valid,
  input  logic            r_eq_0,
  output logic [PC_W-1:0] pm_addr,
  output logic            rom_req,
  output logic [PC_W-1:0] pc,
  output logic [7:0]      ir,
  output logic [3:0]      nibble_ir,
  output logic [3:0]      source_sel,
  output logic [8:0]      reg_en,
  output logic            i_sel,
  output logic            x_sel,
  output logic            y_sel,
  output logic            executing
);

  state_t          state;
  logic [3:0]      dec_source_sel;
  logic [8:0]      dec_reg_en;
  logic            dec_i_sel;
  logic            dec_x_sel;
  logic            dec_y_sel;
  logic            dec_jump_taken;
  logic [7:0]      dec_jump_target;
  logic [PC_W-1:0] jump_pc;

  instruction_decode u_decode (
    .ir          (ir),
    .r_eq_0      (r_eq_0),
    .source_sel  (dec_source_sel),
    .reg_en      (dec_reg_en),
    .i_sel       (dec_i_sel),
    .x_sel       (dec_x_sel),
    .y_sel       (dec_y_sel),
    .jump_taken  (dec_jump_taken),
    .jump_target (dec_jump_target)
  );

  assign executing = (state == EXECUTE);
  assign pm_addr   = pc;
  assign nibble_ir = ir[3:0];
  assign jump_pc   = PC_W'(dec_jump_target);

  // Strobes are forced to zero outside the execute cycle so no register is written twice
  assign source_sel = executing ? dec_source_sel : 4'd0;
  assign reg_en     = executing ? dec_reg_en     : 9'd0;
  assign i_sel      = executing & dec_i_sel;
  assign x_sel      = executing & dec_x_sel;
  assign y_sel      = executing & dec_y_sel;

  // Two-state sequencer: hold the ROM request until data returns, then one execute cycle
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      ir      <= 8'h00;
      rom_req <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (rom_req && rom_valid) begin
            ir      <= rom_data;
            rom_req <= 1'b0;
            state   <= EXECUTE;
          end else begin
            rom_req <= 1'b1;
          end
        end
        EXECUTE: begin
          pc      <= dec_jump_taken ? jump_pc : pc + PC_W'(1);
          rom_req <= 1'b1;
          state   <= FETCH;
        end
        default: begin
          state   <= FETCH;
          rom_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_decoder.sv
// tb/tb_instruction_fetch_decoder.sv - self-checking bench for instruction_fetch_decoder
module tb_instruction_fetch_decoder;

  logic       clk = 1'b0;
  logic       sync_reset;
  logic [7:0] rom_data;
  logic       rom_valid;
  logic       r_eq_0;
  logic [7:0] pm_addr;
  logic       rom_req;
  logic [7:0] pc;
  logic [7:0] ir;
  logic [3:0] nibble_ir;
  logic [3:0] source_sel;
  logic [8:0] reg_en;
  logic       i_sel;
  logic       x_sel;
  logic       y_sel;
  logic       executing;

  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] model_pc;

  always #5 clk = ~clk;

  instruction_fetch_decoder #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .rom_data   (rom_data),
    .rom_valid  (rom_valid),
    .r_eq_0     (r_eq_0),
    .pm_addr    (pm_addr),
    .rom_req    (rom_req),
    .pc         (pc),
    .ir         (ir),
    .nibble_ir  (nibble_ir),
    .source_sel (source_sel),
    .reg_en     (reg_en),
    .i_sel      (i_sel),
    .x_sel      (x_sel),
    .y_sel      (y_sel),
    .executing  (executing)
  );

  typedef struct packed {
    logic [3:0] src;
    logic [8:0] en;
    logic       isel;
    logic       xs;
    logic       ys;
    logic       jmp;
    logic [7:0] tgt;
  } dec_t;

  typedef struct {
    logic [7:0] instr;
    int         lat;
    logic       z;
    logic       stray;
    logic [3:0] src;
    logic [8:0] en;
    logic       isel;
    logic       xs;
    logic       ys;
    logic [7:0] pc_next;
  } vec_t;

  vec_t vecs[17];

  // Reference decode written from the ISA rules using numeric opcode ranges
  function automatic dec_t ref_decode(input logic [7:0] i, input logic z);
    dec_t d;
    int   dst_bit[8];
    int   dst;
    int   src;
    dst_bit = '{0, 1, 2, 3, 8, 5, 6, 7};
    d   = '0;
    dst = -1;
    src = -1;
    if (i < 8'h80) begin
      dst   = int'(i[6:4]);
      d.src = 4'd8;
    end else if (i < 8'hC0) begin
      dst   = int'(i[5:3]);
      src   = int'(i[2:0]);
      d.src = (src == dst) ? 4'd9 : 4'(src);
    end else if (i < 8'hE0) begin
      d.xs    = i[4];
      d.ys    = i[3];
      d.en[4] = 1'b1;
    end else begin
      d.jmp = (i < 8'hF0) || !z;
      d.tgt = 8'(i[3:0]) * 8'd16;
    end
    if (dst >= 0) begin
      d.en[dst_bit[dst]] = 1'b1;
      if (dst != 6 && (dst == 7 || d.src == 4'd7)) begin
        d.en[6] = 1'b1;
        d.isel  = 1'b1;
      end
    end
    return d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    sync_reset = 1'b1;
    rom_valid  = 1'b0;
    @(negedge clk);
    sync_reset = 1'b0;
    model_pc   = 8'h00;
  endtask

  // Act as the ROM: answer the pending request on its lat-th cycle, leave the bench at the execute negedge
  task automatic fetch_to_exec(input string name, input logic [7:0] instr, input int lat);
    int cyc;
    cyc = 0;
    while (rom_req !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, " rom_req asserted"}, 32'(rom_req), 32'd1);
    for (int k = 1; k < lat; k++) begin
      chk($sformatf("%s wait%0d pm_addr", name, k), 32'(pm_addr), 32'(model_pc));
      chk($sformatf("%s wait%0d rom_req", name, k), 32'(rom_req), 32'd1);
      chk($sformatf("%s wait%0d reg_en", name, k), 32'(reg_en), 32'd0);
      r_eq_0   = 1'($urandom);
      rom_data = 8'($urandom);
      @(negedge clk);
    end
    chk({name, " pm_addr"}, 32'(pm_addr), 32'(model_pc));
    rom_valid = 1'b1;
    rom_data  = instr;
    @(negedge clk);
    rom_valid = 1'b0;
    rom_data  = 8'($urandom);
  endtask

  // Check strobes in the execute cycle, then the resulting pc and idle strobes
  task automatic exec_check(input string name, input logic [7:0] instr, input logic z,
                            input logic stray, input logic [3:0] e_src, input logic [8:0] e_en,
                            input logic e_isel, input logic e_xs, input logic e_ys,
                            input logic [7:0] e_pc);
    r_eq_0 = z;
    if (stray) begin
      rom_valid = 1'b1;
      rom_data  = ~instr;
    end
    #1;
    chk({name, " executing"}, 32'(executing), 32'd1);
    chk({name, " rom_req"}, 32'(rom_req), 32'd0);
    chk({name, " ir"}, 32'(ir), 32'(instr));
    chk({name, " nibble_ir"}, 32'(nibble_ir), 32'(instr & 8'h0F));
    chk({name, " source_sel"}, 32'(source_sel), 32'(e_src));
    chk({name, " reg_en"}, 32'(reg_en), 32'(e_en));
    chk({name, " i_sel"}, 32'(i_sel), 32'(e_isel));
    chk({name, " x_sel"}, 32'(x_sel), 32'(e_xs));
    chk({name, " y_sel"}, 32'(y_sel), 32'(e_ys));
    @(negedge clk);
    rom_valid = 1'b0;
    model_pc  = e_pc;
    chk({name, " pc"}, 32'(pc), 32'(e_pc));
    chk({name, " after executing"}, 32'(executing), 32'd0);
    chk({name, " after reg_en"}, 32'(reg_en), 32'd0);
    chk({name, " ir held"}, 32'(ir), 32'(instr));
  endtask

  task automatic run_model(input string name, input logic [7:0] instr, input int lat,
                           input logic z, input logic stray);
    dec_t d;
    logic [7:0] nxt;
    d   = ref_decode(instr, z);
    nxt = d.jmp ? d.tgt : model_pc + 8'd1;
    fetch_to_exec(name, instr, lat);
    exec_check(name, instr, z, stray, d.src, d.en, d.isel, d.xs, d.ys, nxt);
  endtask

  initial begin
    sync_reset = 1'b1;
    rom_data   = 8'h00;
    rom_valid  = 1'b0;
    r_eq_0     = 1'b0;
    model_pc   = 8'h00;

    //           instr  lat z  st  src    en      is xs ys pc_next
    vecs[0]  = '{8'h25, 3, 0, 0, 4'd8, 9'h004, 0, 0, 0, 8'h01};
    vecs[1]  = '{8'h89, 1, 0, 1, 4'd9, 9'h002, 0, 0, 0, 8'h02};
    vecs[2]  = '{8'h87, 2, 0, 0, 4'd7, 9'h041, 1, 0, 0, 8'h03};
    vecs[3]  = '{8'hD3, 1, 1, 0, 4'd0, 9'h010, 0, 1, 0, 8'h04};
    vecs[4]  = '{8'h7F, 4, 0, 1, 4'd8, 9'h0C0, 1, 0, 0, 8'h05};
    vecs[5]  = '{8'hF3, 1, 0, 0, 4'd0, 9'h000, 0, 0, 0, 8'h30};
    vecs[6]  = '{8'hE0, 2, 1, 1, 4'd0, 9'h000, 0, 0, 0, 8'h00};
    vecs[7]  = '{8'h40, 1, 1, 0, 4'd8, 9'h100, 0, 0, 0, 8'h01};
    vecs[8]  = '{8'h31, 1, 0, 0, 4'd8, 9'h008, 0, 0, 0, 8'h02};
    vecs[9]  = '{8'h6A, 3, 0, 0, 4'd8, 9'h040, 0, 0, 0, 8'h03};
    vecs[10] = '{8'h17, 1, 1, 0, 4'd8, 9'h002, 0, 0, 0, 8'h04};
    vecs[11] = '{8'hBE, 2, 0, 0, 4'd6, 9'h0C0, 1, 0, 0, 8'h05};
    vecs[12] = '{8'hF3, 1, 1, 0, 4'd0, 9'h000, 0, 0, 0, 8'h06};
    vecs[13] = '{8'hB7, 1, 0, 1, 4'd7, 9'h040, 0, 0, 0, 8'h07};
    vecs[14] = '{8'hBF, 2, 0, 0, 4'd9, 9'h0C0, 1, 0, 0, 8'h08};
    vecs[15] = '{8'hC8, 1, 0, 0, 4'd0, 9'h010, 0, 0, 1, 8'h09};
    vecs[16] = '{8'hE5, 1, 0, 0, 4'd0, 9'h000, 0, 0, 0, 8'h50};

    repeat (2) @(negedge clk);
    sync_reset = 1'b0;
    chk("reset pc", 32'(pc), 32'h00);
    chk("reset ir", 32'(ir), 32'h00);
    chk("reset rom_req", 32'(rom_req), 32'd0);
    chk("reset executing", 32'(executing), 32'd0);
    chk("reset reg_en", 32'(reg_en), 32'd0);
    chk("reset source_sel", 32'(source_sel), 32'd0);
    chk("reset sel bits", 32'({i_sel, x_sel, y_sel}), 32'd0);
    model_pc = 8'h00;

    for (int v = 0; v < 17; v++) begin
      fetch_to_exec($sformatf("vec%0d", v), vecs[v].instr, vecs[v].lat);
      exec_check($sformatf("vec%0d", v), vecs[v].instr, vecs[v].z, vecs[v].stray,
                 vecs[v].src, vecs[v].en, vecs[v].isel, vecs[v].xs, vecs[v].ys,
                 vecs[v].pc_next);
    end

    // pc wrap from FF to 00
    run_model("jmp_f0", 8'hEF, 1, 1'b0, 1'b0);
    chk("jmp_f0 target", 32'(model_pc), 32'hF0);
    while (model_pc != 8'hFF) run_model("climb", 8'($urandom) & 8'h7F, 1, 1'b0, 1'b0);
    fetch_to_exec("wrap", 8'h25, 1);
    exec_check("wrap", 8'h25, 1'b0, 1'b0, 4'd8, 9'h004, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("wrap pm_addr", 32'(pm_addr), 32'h00);
    chk("wrap rom_req", 32'(rom_req), 32'd1);

    // randomized instructions against the reference model
    for (int n = 0; n < 150; n++) begin
      run_model($sformatf("rnd%0d", n), 8'($urandom), int'($urandom_range(1, 4)),
                1'($urandom), 1'($urandom));
    end

    // reset during execute suppresses the pc update
    run_model("pre_exrst", 8'h12, 1, 1'b0, 1'b0);
    fetch_to_exec("exrst", 8'h34, 2);
    sync_reset = 1'b1;
    @(negedge clk);
    sync_reset = 1'b0;
    chk("exrst pc", 32'(pc), 32'h00);
    chk("exrst ir", 32'(ir), 32'h00);
    chk("exrst executing", 32'(executing), 32'd0);
    chk("exrst rom_req", 32'(rom_req), 32'd0);
    model_pc = 8'h00;

    // reset coinciding with rom_valid mid-fetch at pc=7
    for (int n = 0; n < 7; n++) run_model("to7", 8'($urandom) & 8'h7F, 1, 1'b0, 1'b0);
    begin
      int cyc;
      cyc = 0;
      while (rom_req !== 1'b1 && cyc < 10) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("midrst pm_addr before", 32'(pm_addr), 32'h07);
    sync_reset = 1'b1;
    rom_valid  = 1'b1;
    rom_data   = 8'h25;
    @(negedge clk);
    sync_reset = 1'b0;
    chk("midrst ir", 32'(ir), 32'h00);
    chk("midrst pc", 32'(pc), 32'h00);
    chk("midrst reg_en", 32'(reg_en), 32'd0);
    chk("midrst rom_req", 32'(rom_req), 32'd0);
    chk("midrst executing", 32'(executing), 32'd0);
    @(negedge clk);
    rom_valid = 1'b0;
    chk("midrst stray ir", 32'(ir), 32'h00);
    chk("midrst stray executing", 32'(executing), 32'd0);
    chk("midrst restart rom_req", 32'(rom_req), 32'd1);
    chk("midrst restart pm_addr", 32'(pm_addr), 32'h00);
    model_pc = 8'h00;
    run_model("post_midrst", 8'h25, 2, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
